// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART host command frame decoder.
package uart_cmd_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned LEN_W  = 9;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CMD    = 3'd1,
    ADDR_H = 3'd2,
    ADDR_L = 3'd3,
    LEN    = 3'd4,
    DATA   = 3'd5
  } state_e;

  localparam logic [DATA_W-1:0] SYNC_BYTE_DEF = 8'hAA;
  localparam logic [DATA_W-1:0] CMD_WR_DEF    = 8'h01;
  localparam logic [DATA_W-1:0] CMD_RD_DEF    = 8'h02;

  localparam logic [1:0] ERR_CMD = 2'd0;
  localparam logic [1:0] ERR_OVF = 2'd1;
  localparam logic [1:0] ERR_TMO = 2'd2;

  // A LEN byte of zero stands for a full 256-byte transfer.
  function automatic logic [LEN_W-1:0] decode_len(input logic [DATA_W-1:0] b);
    return (b == '0) ? LEN_W'(256) : LEN_W'(b);
  endfunction

endpackage

// File: rtl/uart_cmd_parser.sv
// Decodes UART host frames (SYNC, CMD, ADDR_H, ADDR_L, LEN[, payload]) into SDRAM requests.
// Optional inter-byte timeout enabled by defining UART_CMD_TIMEOUT_EN.
module uart_cmd_parser
  import uart_cmd_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE     = SYNC_BYTE_DEF,
  parameter logic [7:0]  CMD_WR        = CMD_WR_DEF,
  parameter logic [7:0]  CMD_RD        = CMD_RD_DEF,
  parameter int unsigned CLK_FREQ      = 50_000_000,
  parameter int unsigned BAUD          = 9600,
  parameter int unsigned TIMEOUT_BYTES = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              po_flag,
  input  logic              wr_full,
  output logic              wr_start,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [LEN_W-1:0]  wr_len,
  output logic              wr_en,
  output logic [DATA_W-1:0] wr_data,
  output logic              wr_done,
  output logic              rd_start,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [LEN_W-1:0]  rd_len,
  output logic              busy,
  output logic              err,
  output logic [1:0]        err_code
);

  state_e              state_q, state_d;
  logic                is_wr_q, is_wr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LEN_W-1:0]    cnt_q, cnt_d;
  logic                wr_start_q, wr_start_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [LEN_W-1:0]    wr_len_q, wr_len_d;
  logic                wr_en_q, wr_en_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic                wr_done_q, wr_done_d;
  logic                rd_start_q, rd_start_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic [LEN_W-1:0]    rd_len_q, rd_len_d;
  logic                busy_q, busy_d;
  logic                err_q, err_d;
  logic [1:0]          err_code_q, err_code_d;

`ifdef UART_CMD_TIMEOUT_EN
  localparam int unsigned TMO_LIMIT = TIMEOUT_BYTES * 10 * CLK_FREQ / BAUD - 1;
  localparam int unsigned TMO_W     = $clog2(TMO_LIMIT + 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
`else
  logic [31:0] tmo_cfg_unused;
  assign tmo_cfg_unused = CLK_FREQ ^ BAUD ^ TIMEOUT_BYTES;
`endif

  // State register and all registered outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      is_wr_q    <= 1'b0;
      addr_q     <= '0;
      cnt_q      <= '0;
      wr_start_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_len_q   <= '0;
      wr_en_q    <= 1'b0;
      wr_data_q  <= '0;
      wr_done_q  <= 1'b0;
      rd_start_q <= 1'b0;
      rd_addr_q  <= '0;
      rd_len_q   <= '0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= '0;
`ifdef UART_CMD_TIMEOUT_EN
      tmo_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      is_wr_q    <= is_wr_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      wr_start_q <= wr_start_d;
      wr_addr_q  <= wr_addr_d;
      wr_len_q   <= wr_len_d;
      wr_en_q    <= wr_en_d;
      wr_data_q  <= wr_data_d;
      wr_done_q  <= wr_done_d;
      rd_start_q <= rd_start_d;
      rd_addr_q  <= rd_addr_d;
      rd_len_q   <= rd_len_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
`ifdef UART_CMD_TIMEOUT_EN
      tmo_q      <= tmo_d;
`endif
    end
  end

  // Next-state and output decode; the frame advances only on po_flag
  always_comb begin
    state_d    = state_q;
    is_wr_d    = is_wr_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    wr_start_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_len_d   = wr_len_q;
    wr_en_d    = 1'b0;
    wr_data_d  = wr_data_q;
    wr_done_d  = 1'b0;
    rd_start_d = 1'b0;
    rd_addr_d  = rd_addr_q;
    rd_len_d   = rd_len_q;
    err_d      = 1'b0;
    err_code_d = err_code_q;

    if (po_flag) begin
      case (state_q)
        IDLE: begin
          if (rx_data == SYNC_BYTE) state_d = CMD;
        end
        CMD: begin
          if (rx_data == CMD_WR) begin
            is_wr_d = 1'b1;
            state_d = ADDR_H;
          end else if (rx_data == CMD_RD) begin
            is_wr_d = 1'b0;
            state_d = ADDR_H;
          end else begin
            err_d      = 1'b1;
            err_code_d = ERR_CMD;
            state_d    = IDLE;
          end
        end
        ADDR_H: begin
          addr_d[15:8] = rx_data;
          state_d      = ADDR_L;
        end
        ADDR_L: begin
          addr_d[7:0] = rx_data;
          state_d     = LEN;
        end
        LEN: begin
          if (is_wr_q) begin
            wr_start_d = 1'b1;
            wr_addr_d  = addr_q;
            wr_len_d   = decode_len(rx_data);
            cnt_d      = decode_len(rx_data);
            state_d    = DATA;
          end else begin
            rd_start_d = 1'b1;
            rd_addr_d  = addr_q;
            rd_len_d   = decode_len(rx_data);
            state_d    = IDLE;
          end
        end
        DATA: begin
          // A byte arriving while the FIFO is full is dropped but still counted.
          cnt_d = cnt_q - LEN_W'(1);
          if (wr_full) begin
            err_d      = 1'b1;
            err_code_d = ERR_OVF;
          end else begin
            wr_en_d   = 1'b1;
            wr_data_d = rx_data;
          end
          if (cnt_q == LEN_W'(1)) begin
            wr_done_d = 1'b1;
            state_d   = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end

`ifdef UART_CMD_TIMEOUT_EN
    tmo_d = (state_q == IDLE || po_flag) ? '0 : tmo_q + TMO_W'(1);
    if (!po_flag && state_q != IDLE && tmo_q == TMO_W'(TMO_LIMIT)) begin
      err_d      = 1'b1;
      err_code_d = ERR_TMO;
      state_d    = IDLE;
      tmo_d      = '0;
    end
`endif

    busy_d = (state_d != IDLE);
  end

  assign wr_start = wr_start_q;
  assign wr_addr  = wr_addr_q;
  assign wr_len   = wr_len_q;
  assign wr_en    = wr_en_q;
  assign wr_data  = wr_data_q;
  assign wr_done  = wr_done_q;
  assign rd_start = rd_start_q;
  assign rd_addr  = rd_addr_q;
  assign rd_len   = rd_len_q;
  assign busy     = busy_q;
  assign err      = err_q;
  assign err_code = err_code_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Scoreboard bench for uart_cmd_parser: directed frames, expected events queued, monitor compares.
module tb_uart_cmd_parser;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       po_flag = 1'b0;
  logic       wr_full = 1'b0;
  logic       wr_start, wr_en, wr_done, rd_start, busy, err;
  logic [15:0] wr_addr, rd_addr;
  logic [8:0]  wr_len, rd_len;
  logic [7:0]  wr_data;
  logic [1:0]  err_code;

  uart_cmd_parser #(.CLK_FREQ(96_000)) dut (
    .clk(clk), .rstn(rstn), .rx_data(rx_data), .po_flag(po_flag), .wr_full(wr_full),
    .wr_start(wr_start), .wr_addr(wr_addr), .wr_len(wr_len), .wr_en(wr_en),
    .wr_data(wr_data), .wr_done(wr_done), .rd_start(rd_start), .rd_addr(rd_addr),
    .rd_len(rd_len), .busy(busy), .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  localparam int K_RD = 0, K_WS = 1, K_WR = 2, K_ERR = 3;
  typedef struct { int kind; int v1; int v2; int cyc; } ev_t;
  ev_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int last_cyc = 0;

  function automatic string kname(input int k);
    case (k)
      K_RD:    return "rd_start";
      K_WS:    return "wr_start";
      K_WR:    return "wr_en/done";
      default: return "err";
    endcase
  endfunction

  task automatic push(input int k, input int a, input int b, input int c);
    ev_t e;
    e.kind = k; e.v1 = a; e.v2 = b; e.cyc = c;
    exp_q.push_back(e);
  endtask

  task automatic check_ev(input int k, input int a, input int b);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_%s: got a=%0h b=%0h at cycle %0d, required no event", kname(k), a, b, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.v1 != a || e.v2 != b || (e.cyc >= 0 && e.cyc != cyc)) begin
        errors++;
        $display("FAIL %s: got %s a=%0h b=%0h cyc=%0d, required %s a=%0h b=%0h cyc=%0d",
                 kname(e.kind), kname(k), a, b, cyc, kname(e.kind), e.v1, e.v2, e.cyc);
      end
    end
  endtask

  task automatic chk(input string name, input int got, input int req);
    checks++;
    if (got != req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, got, req);
    end
  endtask

  // Monitor: every output event is compared against the next queued expectation
  always @(negedge clk) begin
    if (rstn) begin
      if (rd_start)         check_ev(K_RD, int'(rd_addr), int'(rd_len));
      if (wr_start)         check_ev(K_WS, int'(wr_addr), int'(wr_len));
      if (wr_en || wr_done) check_ev(K_WR, wr_en ? int'(wr_data) : -1, int'(wr_done));
      if (err)              check_ev(K_ERR, int'(err_code), 0);
    end
  end

  // One byte strobe; returns just after the capturing edge, before the monitor samples
  task automatic send(input logic [7:0] b, input logic full);
    @(posedge clk);
    #1;
    rx_data  = b;
    po_flag  = 1'b1;
    wr_full  = full;
    last_cyc = cyc + 1;
    @(posedge clk);
    #1;
    po_flag = 1'b0;
    wr_full = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_pulses"}, int'({wr_start, wr_en, wr_done, rd_start, err}), 0);
    chk({tag, "_wr_addr"}, int'(wr_addr), 0);
    chk({tag, "_wr_len"}, int'(wr_len), 0);
    chk({tag, "_wr_data"}, int'(wr_data), 0);
    chk({tag, "_rd_addr"}, int'(rd_addr), 0);
    chk({tag, "_rd_len"}, int'(rd_len), 0);
    chk({tag, "_err_code"}, int'(err_code), 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rstn = 1'b1;

    // Basic write, LEN=3
    send(8'hAA, 1'b0);
    chk("busy_after_sync", int'(busy), 1);
    send(8'h01, 1'b0); send(8'h12, 1'b0); send(8'h34, 1'b0);
    send(8'h03, 1'b0); push(K_WS, 'h1234, 3, last_cyc);
    send(8'h11, 1'b0); push(K_WR, 'h11, 0, last_cyc);
    send(8'h22, 1'b0); push(K_WR, 'h22, 0, last_cyc);
    send(8'h33, 1'b0); push(K_WR, 'h33, 1, last_cyc);
    chk("busy_after_write", int'(busy), 0);

    // Read with LEN=0 meaning 256
    send(8'hAA, 1'b0); send(8'h02, 1'b0); send(8'h00, 1'b0); send(8'h10, 1'b0);
    send(8'h00, 1'b0); push(K_RD, 'h0010, 256, last_cyc);
    repeat (6) @(posedge clk);
    #1;
    chk("rd_addr_held", int'(rd_addr), 'h0010);
    chk("rd_len_held", int'(rd_len), 256);
    chk("busy_after_read", int'(busy), 0);

    // Junk ignored in IDLE, bad command, then a good read
    send(8'h5A, 1'b0); send(8'h00, 1'b0);
    chk("busy_junk", int'(busy), 0);
    send(8'hAA, 1'b0); send(8'h07, 1'b0); push(K_ERR, 0, 0, last_cyc);
    chk("busy_after_badcmd", int'(busy), 0);
    send(8'hAA, 1'b0); send(8'h02, 1'b0); send(8'h00, 1'b0); send(8'h00, 1'b0);
    send(8'h01, 1'b0); push(K_RD, 'h0000, 1, last_cyc);

    // Overflow on the last payload byte still finishes the frame
    send(8'hAA, 1'b0); send(8'h01, 1'b0); send(8'hAB, 1'b0); send(8'hCD, 1'b0);
    send(8'h02, 1'b0); push(K_WS, 'hABCD, 2, last_cyc);
    send(8'h5E, 1'b0); push(K_WR, 'h5E, 0, last_cyc);
    send(8'h6F, 1'b1); push(K_WR, -1, 1, last_cyc); push(K_ERR, 1, 0, last_cyc);
    repeat (4) @(posedge clk);
    #1;
    chk("err_code_held", int'(err_code), 1);
    chk("wr_data_not_overwritten", int'(wr_data), 'h5E);

    // Reset mid-payload of a LEN=4 frame
    send(8'hAA, 1'b0); send(8'h01, 1'b0); send(8'h00, 1'b0); send(8'h20, 1'b0);
    send(8'h04, 1'b0); push(K_WS, 'h0020, 4, last_cyc);
    send(8'h01, 1'b0); push(K_WR, 'h01, 0, last_cyc);
    send(8'h02, 1'b0); push(K_WR, 'h02, 0, last_cyc);
    @(posedge clk);
    #1;
    rstn = 1'b0;
    #1;
    check_all_zero("midreset");
    @(posedge clk);
    #1;
    rstn = 1'b1;
    send(8'hAA, 1'b0); send(8'h02, 1'b0); send(8'h55, 1'b0); send(8'h66, 1'b0);
    send(8'h80, 1'b0); push(K_RD, 'h5566, 128, last_cyc);

    // Stalled frame after the command byte
    send(8'hAA, 1'b0); send(8'h01, 1'b0);
`ifdef UART_CMD_TIMEOUT_EN
    push(K_ERR, 2, 0, -1);
    repeat (500) @(posedge clk);
    #1;
    chk("busy_after_timeout", int'(busy), 0);
    send(8'hAA, 1'b0); send(8'h02, 1'b0); send(8'h01, 1'b0); send(8'h02, 1'b0);
    send(8'h05, 1'b0); push(K_RD, 'h0102, 5, last_cyc);
`else
    repeat (500) @(posedge clk);
    #1;
    chk("busy_stalled", int'(busy), 1);
    send(8'h00, 1'b0); send(8'h00, 1'b0);
    send(8'h01, 1'b0); push(K_WS, 'h0000, 1, last_cyc);
    send(8'h55, 1'b0); push(K_WR, 'h55, 1, last_cyc);
`endif

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending events, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_cmd_parser.md
Name: uart_cmd_parser

Overview:
- Sits directly downstream of uart_rx. Consumes its byte stream (rx_data qualified by po_flag) and decodes host command frames into SDRAM-side requests.
- Write frames produce a start pulse with address and length, then a byte stream for the SDRAM write FIFO.
- Read frames produce a single read-request pulse with address and length. The read path returns data through the tx side.

Parameters:
- SYNC_BYTE, 8'hAA, frame start marker
- CMD_WR, 8'h01, write command code
- CMD_RD, 8'h02, read command code
- CLK_FREQ, 50_000_000, clk frequency in Hz
- BAUD, 9600, UART baud rate
- TIMEOUT_BYTES, 4, inter-byte timeout in 10-bit character times (used only with the optional feature)

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- rx_data  in  8  received byte from uart_rx
- po_flag  in  1  one-cycle strobe; rx_data valid
- wr_full  in  1  downstream write FIFO full
- wr_start  out  1  one-cycle pulse; wr_addr/wr_len valid
- wr_addr  out  16  write start address
- wr_len  out  9  write byte count, 1..256
- wr_en  out  1  one-cycle strobe; wr_data valid
- wr_data  out  8  write payload byte
- wr_done  out  1  one-cycle pulse after the last payload byte
- rd_start  out  1  one-cycle pulse; rd_addr/rd_len valid
- rd_addr  out  16  read start address
- rd_len  out  9  read byte count, 1..256
- busy  out  1  high whenever state != IDLE
- err  out  1  one-cycle error pulse
- err_code  out  2  0 bad cmd, 1 FIFO overflow, 2 timeout; held until the next err

Behaviour:
- Reset: every output is 0; state is IDLE; all counters are 0. Reset is asynchronous; asserting it mid-frame discards the frame with no pulses.
- Frame format:
  - Write: SYNC, CMD_WR, ADDR_H, ADDR_L, LEN, then N payload bytes.
  - Read: SYNC, CMD_RD, ADDR_H, ADDR_L, LEN.
- LEN = 0 encodes 256. wr_len/rd_len = (LEN == 0) ? 256 : LEN.
- The FSM advances only on cycles where po_flag = 1. States: IDLE -> CMD -> ADDR_H -> ADDR_L -> LEN -> DATA (write only) -> IDLE.
- IDLE: a byte != SYNC_BYTE is silently ignored. SYNC_BYTE moves to CMD.
- CMD:
  - CMD_WR or CMD_RD is latched, then go to ADDR_H.
  - Any other value, including SYNC_BYTE: err = 1, err_code = 0, return to IDLE.
- LEN state, CMD_RD: rd_start pulses the cycle after the LEN byte's po_flag, with rd_addr/rd_len stable from that cycle until the next rd_start. Return to IDLE.
- LEN state, CMD_WR: wr_start pulses the cycle after the LEN byte's po_flag, with wr_addr/wr_len stable until the next wr_start. Load the remaining-count counter, go to DATA.
- DATA:
  - Each po_flag produces wr_en = 1 and wr_data = rx_data on the next cycle (latency 1), and decrements the counter.
  - The byte that takes the count to 0 also pulses wr_done in the same cycle as its wr_en; the state returns to IDLE.
- Overflow: if wr_full = 1 on the cycle a payload byte arrives:
  - the byte is dropped (no wr_en) but still counted;
  - err = 1, err_code = 1;
  - the frame continues, and wr_done still fires at the end.
- po_flag is never asserted on consecutive cycles, so no input queuing is needed.
- busy goes high the cycle after SYNC is accepted and low the cycle the FSM re-enters IDLE.

Optional Feature:
- Macro: UART_CMD_TIMEOUT_EN.
- Defined:
  - A cycle counter is cleared on every po_flag and while in IDLE.
  - When it reaches TIMEOUT_BYTES*10*CLK_FREQ/BAUD - 1 outside IDLE: err = 1, err_code = 2, state returns to IDLE.
  - A partial write frame gets no wr_done.
- Undefined: no counter; a stalled frame waits indefinitely.

Decomposition:
- Shared package uart_cmd_pkg holds:
  - the state enum (IDLE, CMD, ADDR_H, ADDR_L, LEN, DATA);
  - SYNC/command code constants;
  - err_code constants (ERR_CMD = 0, ERR_OVF = 1, ERR_TMO = 2).
- No sub-module needed. The timeout counter is small enough to stay inline within the optional-feature guard.

Test Plan:
- Bytes AA 01 12 34 03 11 22 33 with wr_full = 0 -> wr_start with wr_addr = 16'h1234, wr_len = 3. Then wr_en x3 carrying 11, 22, 33, each 1 cycle after its po_flag. wr_done coincides with the 33 strobe. busy is low afterwards.
- Bytes AA 02 00 10 00 -> one rd_start, rd_addr = 16'h0010, rd_len = 256. No wr_* activity.
- Bytes 5A 00 AA 07 -> the first two bytes are ignored. After 07: err pulse, err_code = 0, IDLE. A following AA 02 00 00 01 decodes normally.
- Write frame with LEN = 2 and wr_full = 1 during the second payload byte -> one wr_en, err with err_code = 1, wr_done still pulses.
- With UART_CMD_TIMEOUT_EN: send AA 01 then idle for more than 4 character times -> err, err_code = 2, busy drops. Without the macro -> busy stays high.
- Assert rstn = 0 mid-payload of a LEN = 4 frame -> all outputs 0 immediately. A subsequent full frame decodes correctly.
